// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the multiplier/divider family: widths, constants,
// FSM state encodings and the divider's working-register payload.
package fp32_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned EXP_W       = 10;
    localparam int unsigned EXP_FIELD_W = 8;
    localparam int unsigned FRAC_W      = 23;
    localparam int unsigned MAN_W       = 24;
    localparam int unsigned QUOT_W      = 27;
    localparam int unsigned STATE_W     = 4;

    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_INF = 255;
    localparam logic [WORD_W-1:0] QNAN = 32'hFFC00000;

    typedef logic signed [EXP_W-1:0] exp_t;

    localparam exp_t EXP_MAX    = 10'sd128;
    localparam exp_t EXP_TOP    = 10'sd127;
    localparam exp_t EXP_MIN    = -10'sd126;
    localparam exp_t EXP_DENORM = -10'sd127;

    typedef enum logic [STATE_W-1:0] {
        get_a         = 4'd0,
        get_b         = 4'd1,
        unpack        = 4'd2,
        special_cases = 4'd3,
        normalise_a   = 4'd4,
        normalise_b   = 4'd5,
        divide_0      = 4'd6,
        divide_1      = 4'd7,
        divide_2      = 4'd8,
        divide_3      = 4'd9,
        normalise_1   = 4'd10,
        normalise_2   = 4'd11,
        round         = 4'd12,
        pack          = 4'd13,
        put_z         = 4'd14
    } state_t;

    typedef struct packed {
        logic                   sign;
        logic [EXP_FIELD_W-1:0] exp;
        logic [FRAC_W-1:0]      frac;
    } fp32_t;

    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic [WORD_W-1:0] z;
        logic [MAN_W-1:0]  a_m;
        logic [MAN_W-1:0]  b_m;
        logic [MAN_W-1:0]  z_m;
        exp_t              a_e;
        exp_t              b_e;
        exp_t              z_e;
        logic              a_s;
        logic              b_s;
        logic              z_s;
        logic              guard;
        logic              round_bit;
        logic              sticky;
    } div_dp_t;

    function automatic logic [WORD_W-1:0] signed_inf(input logic s);
        return {s, 8'hFF, 23'd0};
    endfunction

    function automatic logic [WORD_W-1:0] signed_zero(input logic s);
        return {s, 31'd0};
    endfunction

endpackage

// File: rtl/fp32_div_if.sv
// Stream handshake bundle for the FP32 divider: two operand ports and one result port.
interface fp32_div_if;
    import fp32_pkg::*;

    logic [WORD_W-1:0] input_a;
    logic              input_a_stb;
    logic              input_a_ack;
    logic [WORD_W-1:0] input_b;
    logic              input_b_stb;
    logic              input_b_ack;
    logic [WORD_W-1:0] output_z;
    logic              output_z_stb;
    logic              output_z_ack;

    modport master (
        output input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
        input  input_a_ack, input_b_ack, output_z, output_z_stb
    );

    modport slave (
        input  input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
        output input_a_ack, input_b_ack, output_z, output_z_stb
    );

endinterface

// File: rtl/fp32_div_iter.sv
// Restoring mantissa divider: shift step and compare/subtract step are strobed
// separately by the controller; done_c marks the 50th subtract step.
module fp32_div_iter
    import fp32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              shift,
    input  logic              sub,
    input  logic [MAN_W-1:0]  a_m,
    input  logic [MAN_W-1:0]  b_m,
    output logic [QUOT_W-1:0] quotient,
    output logic              rem_nonzero_c,
    output logic              done_c
);

    localparam int unsigned DIVIDEND_W = 50;
    localparam int unsigned REM_W      = 26;
    localparam int unsigned COUNT_W    = 6;
    localparam int unsigned LAST_ITER  = 49;

    logic [DIVIDEND_W-1:0] dividend;
    logic [MAN_W-1:0]      divisor;
    logic [REM_W-1:0]      remainder;
    logic [COUNT_W-1:0]    count;

    assign done_c        = (count == COUNT_W'(LAST_ITER));
    assign rem_nonzero_c = (remainder != '0);

    // Quotient only ever spans 27 bits since both mantissas are normalised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend  <= '0;
            divisor   <= '0;
            remainder <= '0;
            quotient  <= '0;
            count     <= '0;
        end else if (start) begin
            dividend  <= {a_m, {(DIVIDEND_W-MAN_W){1'b0}}};
            divisor   <= b_m;
            remainder <= '0;
            quotient  <= '0;
            count     <= '0;
        end else if (shift) begin
            quotient  <= {quotient[QUOT_W-2:0], 1'b0};
            remainder <= {remainder[REM_W-2:0], dividend[DIVIDEND_W-1]};
            dividend  <= {dividend[DIVIDEND_W-2:0], 1'b0};
        end else if (sub) begin
            if (remainder >= REM_W'(divisor)) begin
                quotient[0] <= 1'b1;
                remainder   <= remainder - REM_W'(divisor);
            end
            if (!done_c) begin
                count <= count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fp32_divider.sv
// Multi-cycle IEEE-754 single-precision divider z = a / b with stb/ack streams,
// round-to-nearest-even and subnormal support.
module fp32_divider
    import fp32_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fp32_div_if.slave          io,
    output logic [STATE_W-1:0] state
);

    state_t            state_q, state_d;
    div_dp_t           dp_q, dp_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic              z_stb_q, z_stb_d;
    logic [WORD_W-1:0] z_out_q, z_out_d;

    logic              start_c, shift_c, sub_c;
    logic [QUOT_W-1:0] quotient;
    logic              rem_nonzero_c, done_c;

    fp32_t fa, fb;
    logic  z_sign;
    logic  a_max, b_max, a_nan, b_nan, a_zero, b_zero;

    assign fa     = dp_q.a;
    assign fb     = dp_q.b;
    assign z_sign = dp_q.a_s ^ dp_q.b_s;
    assign a_max  = (dp_q.a_e == EXP_MAX);
    assign b_max  = (dp_q.b_e == EXP_MAX);
    assign a_nan  = a_max && (dp_q.a_m != '0);
    assign b_nan  = b_max && (dp_q.b_m != '0);
    assign a_zero = (dp_q.a_e == EXP_DENORM) && (dp_q.a_m == '0);
    assign b_zero = (dp_q.b_e == EXP_DENORM) && (dp_q.b_m == '0);

    assign state           = state_q;
    assign io.input_a_ack  = a_ack_q;
    assign io.input_b_ack  = b_ack_q;
    assign io.output_z_stb = z_stb_q;
    assign io.output_z     = z_out_q;

    fp32_div_iter u_iter (
        .clk           (clk),
        .rst           (rst),
        .start         (start_c),
        .shift         (shift_c),
        .sub           (sub_c),
        .a_m           (dp_q.a_m),
        .b_m           (dp_q.b_m),
        .quotient      (quotient),
        .rem_nonzero_c (rem_nonzero_c),
        .done_c        (done_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= get_a;
            dp_q    <= '0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            z_stb_q <= 1'b0;
            z_out_q <= '0;
        end else begin
            state_q <= state_d;
            dp_q    <= dp_d;
            a_ack_q <= a_ack_d;
            b_ack_q <= b_ack_d;
            z_stb_q <= z_stb_d;
            z_out_q <= z_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dp_d    = dp_q;
        a_ack_d = a_ack_q;
        b_ack_d = b_ack_q;
        z_stb_d = z_stb_q;
        z_out_d = z_out_q;
        start_c = 1'b0;
        shift_c = 1'b0;
        sub_c   = 1'b0;

        case (state_q)
            get_a: begin
                a_ack_d = 1'b1;
                if (a_ack_q && io.input_a_stb) begin
                    dp_d.a  = io.input_a;
                    a_ack_d = 1'b0;
                    state_d = get_b;
                end
            end
            get_b: begin
                b_ack_d = 1'b1;
                if (b_ack_q && io.input_b_stb) begin
                    dp_d.b  = io.input_b;
                    b_ack_d = 1'b0;
                    state_d = unpack;
                end
            end
            unpack: begin
                dp_d.a_m = {1'b0, fa.frac};
                dp_d.b_m = {1'b0, fb.frac};
                dp_d.a_e = EXP_W'(fa.exp) - EXP_W'(BIAS);
                dp_d.b_e = EXP_W'(fb.exp) - EXP_W'(BIAS);
                dp_d.a_s = fa.sign;
                dp_d.b_s = fb.sign;
                state_d  = special_cases;
            end
            special_cases: begin
                state_d = put_z;
                if (a_nan || b_nan) begin
                    dp_d.z = QNAN;
                end else if (a_max) begin
                    dp_d.z = b_max ? QNAN : signed_inf(z_sign);
                end else if (b_max) begin
                    dp_d.z = signed_zero(z_sign);
                end else if (b_zero) begin
                    dp_d.z = a_zero ? QNAN : signed_inf(z_sign);
                end else if (a_zero) begin
                    dp_d.z = signed_zero(z_sign);
                end else begin
                    // Subnormals keep the hidden bit clear and sit at the minimum exponent.
                    if (dp_q.a_e == EXP_DENORM) dp_d.a_e = EXP_MIN;
                    else                        dp_d.a_m[MAN_W-1] = 1'b1;
                    if (dp_q.b_e == EXP_DENORM) dp_d.b_e = EXP_MIN;
                    else                        dp_d.b_m[MAN_W-1] = 1'b1;
                    state_d = normalise_a;
                end
            end
            normalise_a: begin
                if (dp_q.a_m[MAN_W-1]) begin
                    state_d = normalise_b;
                end else begin
                    dp_d.a_m = {dp_q.a_m[MAN_W-2:0], 1'b0};
                    dp_d.a_e = dp_q.a_e - EXP_W'(1);
                end
            end
            normalise_b: begin
                if (dp_q.b_m[MAN_W-1]) begin
                    state_d = divide_0;
                end else begin
                    dp_d.b_m = {dp_q.b_m[MAN_W-2:0], 1'b0};
                    dp_d.b_e = dp_q.b_e - EXP_W'(1);
                end
            end
            divide_0: begin
                dp_d.z_s = z_sign;
                dp_d.z_e = dp_q.a_e - dp_q.b_e;
                start_c  = 1'b1;
                state_d  = divide_1;
            end
            divide_1: begin
                shift_c = 1'b1;
                state_d = divide_2;
            end
            divide_2: begin
                sub_c   = 1'b1;
                state_d = done_c ? divide_3 : divide_1;
            end
            divide_3: begin
                dp_d.z_m       = quotient[QUOT_W-1:3];
                dp_d.guard     = quotient[2];
                dp_d.round_bit = quotient[1];
                dp_d.sticky    = quotient[0] | rem_nonzero_c;
                state_d        = normalise_1;
            end
            normalise_1: begin
                if (!dp_q.z_m[MAN_W-1]) begin
                    dp_d.z_m       = {dp_q.z_m[MAN_W-2:0], dp_q.guard};
                    dp_d.guard     = dp_q.round_bit;
                    dp_d.round_bit = 1'b0;
                    dp_d.z_e       = dp_q.z_e - EXP_W'(1);
                end else begin
                    state_d = normalise_2;
                end
            end
            normalise_2: begin
                // Denormalise results below the smallest normal exponent.
                if ($signed(dp_q.z_e) < EXP_MIN) begin
                    dp_d.z_m       = dp_q.z_m >> 1;
                    dp_d.guard     = dp_q.z_m[0];
                    dp_d.round_bit = dp_q.guard;
                    dp_d.sticky    = dp_q.sticky | dp_q.round_bit;
                    dp_d.z_e       = dp_q.z_e + EXP_W'(1);
                end else begin
                    state_d = round;
                end
            end
            round: begin
                if (dp_q.guard && (dp_q.round_bit || dp_q.sticky || dp_q.z_m[0])) begin
                    dp_d.z_m = dp_q.z_m + MAN_W'(1);
                    if (dp_q.z_m == '1) dp_d.z_e = dp_q.z_e + EXP_W'(1);
                end
                state_d = pack;
            end
            pack: begin
                dp_d.z = {dp_q.z_s, dp_q.z_e[EXP_FIELD_W-1:0] + EXP_FIELD_W'(BIAS),
                          dp_q.z_m[FRAC_W-1:0]};
                if ((dp_q.z_e == EXP_MIN) && !dp_q.z_m[MAN_W-1]) begin
                    dp_d.z = {dp_q.z_s, {EXP_FIELD_W{1'b0}}, dp_q.z_m[FRAC_W-1:0]};
                end
                if ($signed(dp_q.z_e) > EXP_TOP) begin
                    dp_d.z = signed_inf(dp_q.z_s);
                end
                state_d = put_z;
            end
            put_z: begin
                z_stb_d = 1'b1;
                z_out_d = dp_q.z;
                if (z_stb_q && io.output_z_ack) begin
                    z_stb_d = 1'b0;
                    state_d = get_a;
                end
            end
            default: begin
                state_d = get_a;
            end
        endcase
    end

endmodule

// File: tb/tb_fp32_divider.sv
// Directed bench for fp32_divider: arithmetic vectors, specials, range limits,
// handshake holding and asynchronous reset abort.
module tb_fp32_divider;
    import fp32_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] state;
    int         checks = 0;
    int         errors = 0;

    fp32_div_if io();

    fp32_divider dut (
        .clk   (clk),
        .rst   (rst),
        .io    (io),
        .state (state)
    );

    always #5 clk = ~clk;

    localparam int NVEC = 12;
    logic [31:0] vec_a [NVEC] = '{32'h40C00000, 32'hC0C00000, 32'h3F800000, 32'h3F800000,
                                  32'h00000000, 32'h7F800000, 32'hFF800000, 32'h40000000,
                                  32'h7FC00001, 32'h7F7FFFFF, 32'h00800000, 32'h00400000};
    logic [31:0] vec_b [NVEC] = '{32'h40000000, 32'h40000000, 32'h40400000, 32'h00000000,
                                  32'h00000000, 32'h7F800000, 32'h40000000, 32'h7F800000,
                                  32'h3F800000, 32'h3F000000, 32'h40000000, 32'h3F000000};
    logic [31:0] vec_z [NVEC] = '{32'h40400000, 32'hC0400000, 32'h3EAAAAAB, 32'h7F800000,
                                  32'hFFC00000, 32'hFFC00000, 32'hFF800000, 32'h00000000,
                                  32'hFFC00000, 32'h7F800000, 32'h00400000, 32'h00800000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns #1 after the b-capture edge.
    task automatic send_ab(input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clk);
        io.input_a     = a;
        io.input_a_stb = 1'b1;
        n = 0;
        while (!io.input_a_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("a_ack_seen", 32'(io.input_a_ack), 32'd1);
        @(posedge clk);
        #1;
        io.input_a_stb = 1'b0;
        io.input_b     = b;
        io.input_b_stb = 1'b1;
        @(negedge clk);
        n = 0;
        while (!io.input_b_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b_ack_seen", 32'(io.input_b_ack), 32'd1);
        @(posedge clk);
        #1;
        io.input_b_stb = 1'b0;
    endtask

    // Counts edges from the b-capture edge until the result strobe appears.
    task automatic wait_z(output logic [31:0] z, output int lat);
        lat = 0;
        while (!io.output_z_stb && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("z_stb_seen", 32'(io.output_z_stb), 32'd1);
        z = io.output_z;
    endtask

    task automatic accept_z();
        @(negedge clk);
        io.output_z_ack = 1'b1;
        @(posedge clk);
        #1;
        io.output_z_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] z;
        int          lat;
        int          bad;
        int          n;

        rst             = 1'b1;
        io.input_a      = '0;
        io.input_a_stb  = 1'b0;
        io.input_b      = '0;
        io.input_b_stb  = 1'b0;
        io.output_z_ack = 1'b0;
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_a_ack", 32'(io.input_a_ack), 32'd0);
        check("rst_b_ack", 32'(io.input_b_ack), 32'd0);
        check("rst_z_stb", 32'(io.output_z_stb), 32'd0);
        check("rst_z", io.output_z, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            send_ab(vec_a[i], vec_b[i]);
            wait_z(z, lat);
            check($sformatf("vec%0d_%h_%h", i, vec_a[i], vec_b[i]), z, vec_z[i]);
            if (i == 0) check("lat_6_2", 32'(lat), 32'd111);
            accept_z();
        end

        // Result held while the consumer stalls.
        send_ab(32'h40C00000, 32'h40000000);
        wait_z(z, lat);
        check("hs_z", z, 32'h40400000);
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (io.output_z_stb !== 1'b1 || io.output_z !== z ||
                io.input_a_ack !== 1'b0 || io.input_b_ack !== 1'b0) bad++;
        end
        check("hold_20", 32'(bad), 32'd0);

        // Consume result with a_stb already asserted before ack rises.
        @(negedge clk);
        io.output_z_ack = 1'b1;
        io.input_a      = 32'h40000000;
        io.input_a_stb  = 1'b1;
        @(posedge clk);
        #1;
        io.output_z_ack = 1'b0;
        check("hs_stb_drop", 32'(io.output_z_stb), 32'd0);
        check("hs_back_get_a", 32'(state), 32'd0);
        check("hs_a_ack_low", 32'(io.input_a_ack), 32'd0);
        @(posedge clk);
        #1;
        check("hs_a_ack_rise", 32'(io.input_a_ack), 32'd1);
        check("hs_no_early_cap", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        io.input_a_stb = 1'b0;
        check("hs_a_captured", 32'(state), 32'd1);
        bad = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (state !== 4'd1 || io.input_b_ack !== 1'b1) bad++;
        end
        check("hs_b_wait", 32'(bad), 32'd0);
        @(negedge clk);
        io.input_b     = 32'h40400000;
        io.input_b_stb = 1'b1;
        @(posedge clk);
        #1;
        io.input_b_stb = 1'b0;
        check("hs_b_captured", 32'(state), 32'd2);
        wait_z(z, lat);
        check("two_thirds", z, 32'h3F2AAAAB);
        check("lat_2_3", 32'(lat), 32'd112);
        accept_z();

        // Asynchronous reset mid-division.
        send_ab(32'h40C00000, 32'h40000000);
        n = 0;
        while (state !== 4'd7 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_divide_1", 32'(state), 32'd7);
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_a_ack", 32'(io.input_a_ack), 32'd0);
        check("arst_b_ack", 32'(io.input_b_ack), 32'd0);
        check("arst_z_stb", 32'(io.output_z_stb), 32'd0);
        check("arst_z", io.output_z, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_ab(32'h40C00000, 32'h40000000);
        wait_z(z, lat);
        check("post_rst_6_2", z, 32'h40400000);
        accept_z();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
